// File: rtl/conv_layer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_layer_pkg
//  Description : Shared command/ack encodings for the conv-layer input
//                interface and the controller state type.
//  Revision    : 1.0  initial release
// ============================================================================
package conv_layer_pkg;

   // Command codes driven by the controller towards the input interface
   localparam logic [1:0] CMD_IDLE    = 2'd0;
   localparam logic [1:0] CMD_PRELOAD = 2'd1;
   localparam logic [1:0] CMD_SHIFT   = 2'd2;
   localparam logic [1:0] CMD_LOAD    = 2'd3;

   // Completion codes returned by the input interface
   localparam logic [1:0] ACK_IDLE        = 2'd0;
   localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
   localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
   localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_PRE_REQ  = 4'd1,
      S_PRE_WAIT = 4'd2,
      S_SH_REQ   = 4'd3,
      S_SH_WAIT  = 4'd4,
      S_LD_REQ   = 4'd5,
      S_LD_WAIT  = 4'd6,
      S_DONE     = 4'd7,
      S_ERR      = 4'd8
   } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/conv_layer_ack_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : conv_layer_ack_watchdog
//  Description : Cycle counter bounding the time spent waiting for an ack.
//                Counts while en_i is high, saturates at TIMEOUT-1 and
//                flags expiry on the cycle the count sits at TIMEOUT-1.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                clr_i        - restart the count at zero
//                en_i         - count this cycle (controller is waiting)
//                expired_o    - wait budget exhausted this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module conv_layer_ack_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int               CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = en_i && (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/conv_layer_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv_layer_input_ctrl
//  Description : Command initiator for the conv-layer input interface.
//                Walks one image through PRELOAD, then alternating
//                SHIFT/LOAD, reporting each finished output row and frame
//                completion; a watchdog turns a stalled ack into err.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                start_i         - frame request (honoured in idle/error)
//                abort_i         - return to idle next cycle, top priority
//                ack_i[1:0]      - interface completion code
//                cmd_o[1:0]      - single-cycle interface command
//                if_enable_o     - interface enable (mirrors busy)
//                busy_o          - frame in progress
//                row_valid_o     - pulse: row row_idx_o finished
//                row_idx_o       - current output row
//                done_o          - pulse: frame finished
//                err_o           - sticky ack-timeout error
//  Revision    : 1.0  initial release
// ============================================================================
module conv_layer_input_ctrl
   import conv_layer_pkg::*;
#(
   parameter int KERNEL_SIZE = 3,
   parameter int IMAGE_SIZE  = 8,
   parameter int NUM_ROWS    = IMAGE_SIZE - KERNEL_SIZE + 1,
   parameter int TIMEOUT     = 64,
   parameter int ROW_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [1:0]       ack_i,
   output logic [1:0]       cmd_o,
   output logic             if_enable_o,
   output logic             busy_o,
   output logic             row_valid_o,
   output logic [ROW_W-1:0] row_idx_o,
   output logic             done_o,
   output logic             err_o
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

   ctrl_state_t      state_q,     state_d;
   logic [1:0]       cmd_q,       cmd_d;
   logic             busy_q,      busy_d;
   logic             row_valid_q, row_valid_d;
   logic [ROW_W-1:0] row_idx_q,   row_idx_d;
   logic             done_q,      done_d;
   logic             err_q,       err_d;

   logic wd_clr;
   logic wd_en;
   logic wd_expired;

   // Every WAIT state is entered from its REQ state, so clearing during the
   // REQ cycle makes the count start at zero on the first WAIT cycle.
   assign wd_clr = state_q inside {S_PRE_REQ, S_SH_REQ, S_LD_REQ};
   assign wd_en  = state_q inside {S_PRE_WAIT, S_SH_WAIT, S_LD_WAIT};

   conv_layer_ack_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (wd_clr),
      .en_i      (wd_en),
      .expired_o (wd_expired)
   );

   always_comb begin
      state_d     = state_q;
      row_idx_d   = row_idx_q;
      row_valid_d = 1'b0;

      // A matching ack is tested before expiry so it wins on the last cycle.
      case (state_q)
         S_IDLE, S_ERR: begin
            if (start_i) begin
               state_d   = S_PRE_REQ;
               row_idx_d = '0;
            end
         end
         S_PRE_REQ: state_d = S_PRE_WAIT;
         S_PRE_WAIT: begin
            if (ack_i == ACK_PRELOAD_FIN) begin
               state_d = S_SH_REQ;
            end else if (wd_expired) begin
               state_d = S_ERR;
            end
         end
         S_SH_REQ: state_d = S_SH_WAIT;
         S_SH_WAIT: begin
            if (ack_i == ACK_SHIFT_FIN) begin
               row_valid_d = 1'b1;
               state_d     = (row_idx_q == LAST_ROW) ? S_DONE : S_LD_REQ;
            end else if (wd_expired) begin
               state_d = S_ERR;
            end
         end
         S_LD_REQ: state_d = S_LD_WAIT;
         S_LD_WAIT: begin
            if (ack_i == ACK_LOAD_FIN) begin
               row_idx_d = row_idx_q + 1'b1;
               state_d   = S_SH_REQ;
            end else if (wd_expired) begin
               state_d = S_ERR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort_i) begin
         state_d     = S_IDLE;
         row_idx_d   = '0;
         row_valid_d = 1'b0;
      end

      // Outputs are registered copies of what the next state implies, so
      // they line up with the state the FSM occupies.
      case (state_d)
         S_PRE_REQ: cmd_d = CMD_PRELOAD;
         S_SH_REQ:  cmd_d = CMD_SHIFT;
         S_LD_REQ:  cmd_d = CMD_LOAD;
         default:   cmd_d = CMD_IDLE;
      endcase
      busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERR});
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cmd_q       <= CMD_IDLE;
         busy_q      <= 1'b0;
         row_valid_q <= 1'b0;
         row_idx_q   <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         busy_q      <= busy_d;
         row_valid_q <= row_valid_d;
         row_idx_q   <= row_idx_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign cmd_o       = cmd_q;
   assign busy_o      = busy_q;
   assign if_enable_o = busy_q;
   assign row_valid_o = row_valid_q;
   assign row_idx_o   = row_idx_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_layer_input_ctrl
//  Description : Self-checking bench for conv_layer_input_ctrl. A responder
//                acks each command after a programmable delay; expected
//                command/row/done cycles come from an event-timing model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_layer_input_ctrl;
   import conv_layer_pkg::*;

   localparam int NUM_ROWS = 6;
   localparam int NCMD     = 2 * NUM_ROWS;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] ack   = 2'd0;
   logic [1:0] cmd;
   logic       if_enable, busy, row_valid, done, err;
   logic [2:0] row_idx;

   always #5 clk = ~clk;

   conv_layer_input_ctrl #(
      .KERNEL_SIZE (3),
      .IMAGE_SIZE  (8),
      .TIMEOUT     (64)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .abort_i     (abort),
      .ack_i       (ack),
      .cmd_o       (cmd),
      .if_enable_o (if_enable),
      .busy_o      (busy),
      .row_valid_o (row_valid),
      .row_idx_o   (row_idx),
      .done_o      (done),
      .err_o       (err)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // observed events
   int         mon_cmd_cyc[$];
   logic [1:0] mon_cmd_code[$];
   int         mon_rv_cyc[$];
   int         mon_rv_idx[$];
   int         mon_done_cyc[$];
   int         busy_cnt, ifen_bad, err_cnt;

   // responder configuration
   bit         resp_en = 1'b0;
   int         d_pre, d_sh, d_ld;
   bit         pend = 1'b0;
   int         due;
   logic [1:0] due_code;
   int         inj_cyc = -1;
   logic [1:0] inj_code = ACK_IDLE;

   // expected event times
   int         exp_cmd_cyc[NCMD];
   logic [1:0] exp_cmd_code[NCMD];
   int         exp_rv_cyc[NUM_ROWS];
   int         exp_done_cyc;

   // Responder drives ack just after the edge; monitor samples on negedge.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (resp_en && pend && cyc == due) begin
            ack  = due_code;
            pend = 1'b0;
         end else if (cyc == inj_cyc) begin
            ack = inj_code;
         end else begin
            ack = ACK_IDLE;
         end
         @(negedge clk);
         if (cmd != CMD_IDLE) begin
            mon_cmd_cyc.push_back(cyc);
            mon_cmd_code.push_back(cmd);
            if (resp_en) begin
               pend = 1'b1;
               case (cmd)
                  CMD_PRELOAD: begin due = cyc + d_pre; due_code = ACK_PRELOAD_FIN; end
                  CMD_SHIFT:   begin due = cyc + d_sh;  due_code = ACK_SHIFT_FIN;   end
                  default:     begin due = cyc + d_ld;  due_code = ACK_LOAD_FIN;    end
               endcase
            end
         end
         if (row_valid) begin
            mon_rv_cyc.push_back(cyc);
            mon_rv_idx.push_back(int'(row_idx));
         end
         if (done) mon_done_cyc.push_back(cyc);
         if (busy) busy_cnt++;
         if (if_enable !== busy) ifen_bad++;
         if (err) err_cnt++;
      end
   end

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Command issued at cycle c is acked in cycle c+d and the next command
   // follows at c+d+1; each SHIFT completion reports its row at that cycle.
   task automatic build_model(input int n, input int dp, input int ds, input int dl);
      int t;
      t = n + 1;
      exp_cmd_cyc[0]  = t;
      exp_cmd_code[0] = CMD_PRELOAD;
      t += dp + 1;
      for (int r = 0; r < NUM_ROWS; r++) begin
         exp_cmd_cyc[2*r+1]  = t;
         exp_cmd_code[2*r+1] = CMD_SHIFT;
         t += ds + 1;
         exp_rv_cyc[r] = t;
         if (r < NUM_ROWS - 1) begin
            exp_cmd_cyc[2*r+2]  = t;
            exp_cmd_code[2*r+2] = CMD_LOAD;
            t += dl + 1;
         end else begin
            exp_done_cyc = t;
         end
      end
   endtask

   task automatic prep(input int dp, input int ds, input int dl);
      goto(cyc + 1);
      pend = 1'b0; resp_en = 1'b1; inj_cyc = -1;
      d_pre = dp; d_sh = ds; d_ld = dl;
      mon_cmd_cyc.delete(); mon_cmd_code.delete();
      mon_rv_cyc.delete();  mon_rv_idx.delete(); mon_done_cyc.delete();
      busy_cnt = 0; ifen_bad = 0; err_cnt = 0;
   endtask

   task automatic kick(input int n);
      goto(n);
      start = 1'b1;
      goto(n + 1);
      start = 1'b0;
   endtask

   task automatic run_frame(input int dp, input int ds, input int dl,
                            input int inj_off, input string name);
      int n;
      prep(dp, ds, dl);
      n = cyc + 1;
      build_model(n, dp, ds, dl);
      if (inj_off > 0) begin
         inj_cyc  = exp_cmd_cyc[1] + inj_off;
         inj_code = ACK_LOAD_FIN;
      end
      kick(n);
      while (mon_done_cyc.size() == 0 && cyc < exp_done_cyc + 50) goto(cyc + 1);
      goto(cyc + 2);
      @(negedge clk);

      n_checks++;
      if (mon_cmd_cyc.size() !== NCMD)
         $display("FAIL %s cmd_count got=%0d exp=%0d", name, mon_cmd_cyc.size(), NCMD);
      else n_pass++;
      for (int i = 0; i < NCMD && i < mon_cmd_cyc.size(); i++) begin
         n_checks++;
         if (mon_cmd_cyc[i] !== exp_cmd_cyc[i] || mon_cmd_code[i] !== exp_cmd_code[i])
            $display("FAIL %s cmd[%0d] got=%0d@%0d exp=%0d@%0d", name, i,
                     mon_cmd_code[i], mon_cmd_cyc[i], exp_cmd_code[i], exp_cmd_cyc[i]);
         else n_pass++;
      end
      n_checks++;
      if (mon_rv_cyc.size() !== NUM_ROWS)
         $display("FAIL %s row_valid_count got=%0d exp=%0d", name, mon_rv_cyc.size(), NUM_ROWS);
      else n_pass++;
      for (int i = 0; i < NUM_ROWS && i < mon_rv_cyc.size(); i++) begin
         n_checks++;
         if (mon_rv_cyc[i] !== exp_rv_cyc[i] || mon_rv_idx[i] !== i)
            $display("FAIL %s row_valid[%0d] got=idx%0d@%0d exp=idx%0d@%0d", name, i,
                     mon_rv_idx[i], mon_rv_cyc[i], i, exp_rv_cyc[i]);
         else n_pass++;
      end
      n_checks++;
      if (mon_done_cyc.size() !== 1)
         $display("FAIL %s done_count got=%0d exp=1", name, mon_done_cyc.size());
      else n_pass++;
      if (mon_done_cyc.size() > 0) begin
         n_checks++;
         if (mon_done_cyc[0] !== exp_done_cyc)
            $display("FAIL %s done_cycle got=%0d exp=%0d", name, mon_done_cyc[0], exp_done_cyc);
         else n_pass++;
      end
      n_checks++;
      if (busy_cnt !== exp_done_cyc - (n + 1))
         $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_cnt, exp_done_cyc - (n + 1));
      else n_pass++;
      n_checks++;
      if (ifen_bad !== 0 || err_cnt !== 0 || busy !== 1'b0)
         $display("FAIL %s idle_after got=ifen_bad%0d err%0d busy%0b exp=0 0 0",
                  name, ifen_bad, err_cnt, busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      start = 1'b1;
      goto(2);
      @(negedge clk);
      n_checks++;
      if ({cmd, if_enable, busy, row_valid, row_idx, done, err} !== 10'd0)
         $display("FAIL reset_outputs got=%b exp=0", {cmd, if_enable, busy, row_valid, row_idx, done, err});
      else n_pass++;
      goto(3);
      start = 1'b0;
      rst_n = 1'b1;
      goto(5);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || cmd !== CMD_IDLE)
         $display("FAIL reset_idle got=busy%0b cmd%0d exp=busy0 cmd0", busy, cmd);
      else n_pass++;
   endtask

   task automatic test_nominal();
      run_frame(27, 11, 9, 0, "nominal");
   endtask

   task automatic test_stale_ack();
      run_frame(27, 11, 9, 5, "stale_ack");
   endtask

   task automatic test_random();
      for (int k = 0; k < 3; k++)
         run_frame(int'($urandom_range(1, 63)), int'($urandom_range(1, 30)),
                   int'($urandom_range(1, 30)), 0, "random");
   endtask

   task automatic test_race();
      run_frame(64, 64, 64, 0, "expiry_race");
   endtask

   task automatic test_timeout();
      int n;
      prep(1, 1, 1);
      resp_en = 1'b0;
      n = cyc + 1;
      kick(n);
      @(negedge clk);
      n_checks++;
      if (cmd !== CMD_PRELOAD || busy !== 1'b1)
         $display("FAIL timeout_preload got=cmd%0d busy%0b exp=cmd1 busy1", cmd, busy);
      else n_pass++;
      goto(n + 65);
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b1)
         $display("FAIL timeout_early got=err%0b busy%0b exp=err0 busy1", err, busy);
      else n_pass++;
      goto(n + 66);
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1 || cmd !== CMD_IDLE || busy !== 1'b0 || if_enable !== 1'b0)
         $display("FAIL timeout_err got=err%0b cmd%0d busy%0b ifen%0b exp=1 0 0 0",
                  err, cmd, busy, if_enable);
      else n_pass++;
      goto(n + 70);
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1)
         $display("FAIL timeout_sticky got=%0b exp=1", err);
      else n_pass++;
      kick(n + 71);
      @(negedge clk);
      n_checks++;
      if (cmd !== CMD_PRELOAD || err !== 1'b0 || busy !== 1'b1)
         $display("FAIL timeout_restart got=cmd%0d err%0b busy%0b exp=cmd1 err0 busy1", cmd, err, busy);
      else n_pass++;
      goto(n + 73);
      abort = 1'b1;
      goto(n + 74);
      abort = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || err !== 1'b0)
         $display("FAIL timeout_abort got=busy%0b err%0b exp=0 0", busy, err);
      else n_pass++;
   endtask

   task automatic test_abort();
      int n, a;
      prep(10, 6, 12);
      n = cyc + 1;
      build_model(n, 10, 6, 12);
      kick(n);
      a = exp_cmd_cyc[8] + 2;   // inside the LOAD wait of row 3
      goto(a);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      n_checks++;
      if (row_idx !== 3'd3 || busy !== 1'b1)
         $display("FAIL abort_pre got=row%0d busy%0b exp=row3 busy1", row_idx, busy);
      else n_pass++;
      goto(a + 1);
      abort = 1'b0;
      start = 1'b0;
      resp_en = 1'b0;
      mon_cmd_cyc.delete();
      mon_cmd_code.delete();
      @(negedge clk);
      n_checks++;
      if ({cmd, if_enable, busy, row_valid, row_idx, done, err} !== 10'd0)
         $display("FAIL abort_idle got=%b exp=0", {cmd, if_enable, busy, row_valid, row_idx, done, err});
      else n_pass++;
      goto(a + 8);
      @(negedge clk);
      n_checks++;
      if (mon_cmd_cyc.size() !== 0 || mon_done_cyc.size() !== 0 || busy !== 1'b0)
         $display("FAIL abort_quiet got=cmds%0d dones%0d busy%0b exp=0 0 0",
                  mon_cmd_cyc.size(), mon_done_cyc.size(), busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int n, s;
      prep(5, 20, 5);
      n = cyc + 1;
      build_model(n, 5, 20, 5);
      kick(n);
      s = exp_cmd_cyc[3] + 3;   // inside the SHIFT wait of row 1
      goto(s);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || row_idx !== 3'd1)
         $display("FAIL rstmid_pre got=busy%0b row%0d exp=busy1 row1", busy, row_idx);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cmd, if_enable, busy, row_valid, row_idx, done, err} !== 10'd0)
         $display("FAIL rstmid_async got=%b exp=0", {cmd, if_enable, busy, row_valid, row_idx, done, err});
      else n_pass++;
      resp_en = 1'b0;
      pend = 1'b0;
      goto(s + 3);
      rst_n = 1'b1;
      start = 1'b1;
      goto(s + 4);
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cmd !== CMD_PRELOAD || busy !== 1'b1 || if_enable !== 1'b1)
         $display("FAIL rstmid_restart got=cmd%0d busy%0b ifen%0b exp=cmd1 1 1", cmd, busy, if_enable);
      else n_pass++;
      goto(s + 5);
      abort = 1'b1;
      goto(s + 6);
      abort = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_stale_ack();
      test_random();
      test_race();
      test_timeout();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard stop in case a wait loop misbehaves.
   initial begin
      #800000;
      $display("FAIL global_timeout got=stalled exp=finished");
      $fatal(1, "bench time limit reached");
   end

endmodule
`default_nettype wire
